fetch_queue: RTL and testbench

//   Instruction fetch queue between instruction fetch (PC + instruction memory) and the decode

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 63 ++++++
 tb/tb_fetch_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode.
// Carries {instr, pcplus4} pairs plus the queue occupancy.
// slave = the queue itself, master = the fetch/decode environment.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_instr;
    logic [WIDTH-1:0] push_pcplus4;
    logic             pop_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_instr;
    logic [WIDTH-1:0] pop_pcplus4;
    logic [AW:0]      count;

    modport slave (
        input  push_valid, push_instr, push_pcplus4, pop_ready,
        output push_ready, pop_valid, pop_instr, pop_pcplus4, count
    );

    modport master (
        output push_valid, push_instr, push_pcplus4, pop_ready,
        input  push_ready, pop_valid, pop_instr, pop_pcplus4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {instr, pcplus4} between fetch and decode, FWFT, NOP when empty.
// Latency: push visible at pop_* one cycle later (no empty bypass); flush/reset empty it in one edge.
// Backpressure: push_ready = ~full from registered count only; a same-cycle pop does not free a slot.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    fetch_queue_if.slave   q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head;

    assign w_full  = (r_cnt == FULL_CNT);
    assign w_empty = (r_cnt == '0);
    // Flush cancels both sides so the wrong-path fetch never lands in storage.
    assign w_push  = q.push_valid & ~w_full & ~flush;
    assign w_pop   = q.pop_ready & ~w_empty & ~flush;
    assign w_head  = r_mem[r_rd_ptr];

    assign q.push_ready  = ~w_full;
    assign q.pop_valid   = ~w_empty;
    assign q.pop_instr   = w_empty ? '0 : w_head[2*WIDTH-1:WIDTH];
    assign q.pop_pcplus4 = w_empty ? '0 : w_head[WIDTH-1:0];
    assign q.count       = r_cnt;

    // Storage write on an accepted push; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= {q.push_instr, q.push_pcplus4};
        end
    end

    // Pointer and occupancy update; reset outranks flush, which outranks push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    logic clk;
    logic reset;
    logic flush;

    fetch_queue_if #(.DEPTH(4), .WIDTH(32)) fq_if ();

    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .q     (fq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        pv;
        logic [31:0] in_i;
        logic [31:0] in_p;
        logic        pr;
        logic        chk_pre;
        logic        e_vld;
        logic        e_rdy;
        logic [31:0] e_i;
        logic [31:0] e_p;
        logic [2:0]  e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic rst, input logic fl, input logic pv,
                                input logic [31:0] i, input logic [31:0] p, input logic pr,
                                input logic ev, input logic er, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [2:0] ec);
        vec_t v;
        v.rst = rst; v.fl = fl; v.pv = pv; v.in_i = i; v.in_p = p; v.pr = pr;
        v.chk_pre = 1'b0;
        v.e_vld = ev; v.e_rdy = er; v.e_i = ei; v.e_p = ep; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ai(input int k); return 32'h2000_0100 + k; endfunction
    function automatic logic [31:0] ap(input int k); return 32'h0000_1000 + 4*k; endfunction
    function automatic logic [31:0] bi(input int k); return 32'h2200_0000 + k; endfunction
    function automatic logic [31:0] bp(input int k); return 32'h0000_2000 + 4*k; endfunction
    function automatic logic [31:0] ci(input int k); return 32'h2300_0000 + k; endfunction
    function automatic logic [31:0] cp(input int k); return 32'h0000_3000 + 4*k; endfunction

    vec_t vq[$];

    initial begin
        vec_t v;
        int   accepted;
        logic rdy;
        logic done;

        reset = 1'b0; flush = 1'b0;
        fq_if.push_valid = 1'b0; fq_if.push_instr = '0; fq_if.push_pcplus4 = '0;
        fq_if.pop_ready = 1'b0;

        // reset, idle
        vq.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0));
        // two pushes, then one pop, then drain
        vq.push_back(mk(0,0,1,32'h20080005,32'h4,0, 1,1,32'h20080005,32'h4,1));
        vq.push_back(mk(0,0,1,32'h20090003,32'h8,0, 1,1,32'h20080005,32'h4,2));
        vq.push_back(mk(0,0,0,0,0,1, 1,1,32'h20090003,32'h8,1));
        vq.push_back(mk(0,0,0,0,0,1, 0,1,0,0,0));
        // fill to full, 5th held until a pop frees a slot
        for (int k = 1; k <= 4; k++)
            vq.push_back(mk(0,0,1,ai(k),ap(k),0, 1,(k<4),ai(1),ap(1),3'(k)));
        vq.push_back(mk(0,0,1,ai(5),ap(5),0, 1,0,ai(1),ap(1),4));
        vq.push_back(mk(0,0,1,ai(5),ap(5),1, 1,1,ai(2),ap(2),3));
        vq.push_back(mk(0,0,1,ai(5),ap(5),0, 1,0,ai(2),ap(2),4));
        for (int k = 3; k <= 5; k++)
            vq.push_back(mk(0,0,0,0,0,1, 1,1,ai(k),ap(k),3'(6-k)));
        vq.push_back(mk(0,0,0,0,0,1, 0,1,0,0,0));
        // fill to 3, then streaming push+pop across pointer wraps
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0,0,1,bi(k),bp(k),0, 1,1,bi(0),bp(0),3'(k+1)));
        for (int k = 3; k <= 8; k++)
            vq.push_back(mk(0,0,1,bi(k),bp(k),1, 1,1,bi(k-2),bp(k-2),3));
        vq.push_back(mk(0,0,0,0,0,1, 1,1,bi(7),bp(7),2));
        vq.push_back(mk(0,0,0,0,0,1, 1,1,bi(8),bp(8),1));
        vq.push_back(mk(0,0,0,0,0,1, 0,1,0,0,0));
        // flush with push and pop in the same cycle
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0,0,1,ci(k),cp(k),0, 1,1,ci(0),cp(0),3'(k+1)));
        vq.push_back(mk(0,1,1,ci(3),cp(3),1, 0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0));
        // push into empty with pop_ready: no bypass
        v = mk(0,0,1,32'hAC0A0000,32'h40,1, 1,1,32'hAC0A0000,32'h40,1);
        v.chk_pre = 1'b1;
        vq.push_back(v);
        // reset with two entries queued
        vq.push_back(mk(0,0,1,32'h24000000,32'h4000,0, 1,1,32'hAC0A0000,32'h40,2));
        vq.push_back(mk(1,0,1,32'h24000004,32'h4004,1, 0,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0));

        foreach (vq[n]) begin
            v = vq[n];
            reset = v.rst; flush = v.fl;
            fq_if.push_valid = v.pv; fq_if.push_instr = v.in_i; fq_if.push_pcplus4 = v.in_p;
            fq_if.pop_ready = v.pr;
            if (v.chk_pre) begin
                #1;
                chk($sformatf("v%0d pre_pop_valid", n), 32'(fq_if.pop_valid), 32'(1'b0));
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d pop_valid", n),   32'(fq_if.pop_valid),  32'(v.e_vld));
            chk($sformatf("v%0d push_ready", n),  32'(fq_if.push_ready), 32'(v.e_rdy));
            chk($sformatf("v%0d pop_instr", n),   fq_if.pop_instr,       v.e_i);
            chk($sformatf("v%0d pop_pcplus4", n), fq_if.pop_pcplus4,     v.e_p);
            chk($sformatf("v%0d count", n),       32'(fq_if.count),      32'(v.e_cnt));
        end

        // Hand sequence: keep pushing until backpressure, count accepted entries.
        reset = 1'b0; flush = 1'b0; fq_if.pop_ready = 1'b0;
        accepted = 0;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            rdy = fq_if.push_ready;
            if (!rdy) begin
                done = 1'b1;
            end else begin
                fq_if.push_valid = 1'b1;
                fq_if.push_instr = 32'h2500_0000 + accepted;
                fq_if.push_pcplus4 = 32'h5000 + 4*accepted;
                @(posedge clk); #1;
                accepted++;
            end
        end
        fq_if.push_valid = 1'b0;
        chk("backpressure_seen", 32'(done), 32'd1);
        chk("accepted_until_full", 32'(accepted), 32'd4);

        // Drain with a bounded loop and check strict order.
        accepted = 0;
        fq_if.pop_ready = 1'b1;
        for (int c = 0; c < 8 && fq_if.pop_valid; c++) begin
            chk($sformatf("drain%0d instr", c), fq_if.pop_instr, 32'h2500_0000 + c);
            chk($sformatf("drain%0d pc", c), fq_if.pop_pcplus4, 32'h5000 + 4*c);
            @(posedge clk); #1;
            accepted++;
        end
        fq_if.pop_ready = 1'b0;
        chk("drained_entries", 32'(accepted), 32'd4);
        chk("drained_count", 32'(fq_if.count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
